// File: rtl/lut_m_cfg_loader.sv
// Serial LSB-first config loader: deserialises MEM_SIZE-bit frames and commits each to one of FRAMES LUTs.
// Optional even-parity check per frame when LUT_CFG_PARITY_EN is defined.
module lut_m_cfg_loader #(
    parameter int INPUTS   = 4,
    parameter int MEM_SIZE = 2**INPUTS,
    parameter int FRAMES   = 4
) (
    input  logic                config_clk,
    input  logic                config_rst,
    input  logic                cfg_start,
    input  logic                cfg_bit,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic [MEM_SIZE-1:0] config_data,
    output logic [FRAMES-1:0]   config_en,
    output logic                cfg_done,
    output logic                cfg_err
);

    localparam int BW = $clog2(MEM_SIZE + 1);
    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

`ifdef LUT_CFG_PARITY_EN
    typedef enum logic [2:0] {IDLE, SHIFT, PAR, COMMIT, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, SHIFT, COMMIT, DONE} state_t;
`endif

    state_t              state;
    state_t              next_state;
    logic [MEM_SIZE-1:0] sr;
    logic [BW-1:0]       bitcnt;
    logic [FW-1:0]       frame;
    logic                done_q;
    logic                xfer;
    logic                last_bit;
    logic                last_frame;
`ifdef LUT_CFG_PARITY_EN
    logic                err_q;
    logic                parity_ok;
    assign parity_ok = ~(^sr ^ cfg_bit);
`endif

    assign xfer       = cfg_valid & cfg_ready;
    assign last_bit   = (bitcnt == BW'(MEM_SIZE - 1));
    assign last_frame = (frame == FW'(FRAMES - 1));

    always_ff @(posedge config_clk) begin
        if (config_rst) state <= IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (cfg_start) next_state = SHIFT;
            SHIFT: begin
                if (cfg_start) next_state = SHIFT;
`ifdef LUT_CFG_PARITY_EN
                else if (xfer && last_bit) next_state = PAR;
`else
                else if (xfer && last_bit) next_state = COMMIT;
`endif
            end
`ifdef LUT_CFG_PARITY_EN
            PAR: begin
                if (cfg_start) next_state = SHIFT;
                else if (xfer) next_state = parity_ok ? COMMIT : DONE;
            end
`endif
            COMMIT: next_state = last_frame ? DONE : SHIFT;
            DONE:   if (cfg_start) next_state = SHIFT;
            default: next_state = IDLE;
        endcase
    end

    // config_data is loaded on the edge that enters COMMIT so it lines up with the config_en pulse.
    always_ff @(posedge config_clk) begin
        if (config_rst) begin
            sr          <= '0;
            bitcnt      <= '0;
            frame       <= '0;
            done_q      <= 1'b0;
            config_data <= '0;
`ifdef LUT_CFG_PARITY_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (cfg_start) begin
                        bitcnt <= '0;
                        frame  <= '0;
                        done_q <= 1'b0;
`ifdef LUT_CFG_PARITY_EN
                        err_q  <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    if (cfg_start) begin
                        bitcnt <= '0;
                        frame  <= '0;
                    end else if (xfer) begin
                        sr     <= {cfg_bit, sr[MEM_SIZE-1:1]};
                        bitcnt <= bitcnt + BW'(1);
`ifndef LUT_CFG_PARITY_EN
                        if (last_bit) config_data <= {cfg_bit, sr[MEM_SIZE-1:1]};
`endif
                    end
                end
`ifdef LUT_CFG_PARITY_EN
                PAR: begin
                    if (cfg_start) begin
                        bitcnt <= '0;
                        frame  <= '0;
                    end else if (xfer) begin
                        if (parity_ok) begin
                            config_data <= sr;
                        end else begin
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                        end
                    end
                end
`endif
                COMMIT: begin
                    if (last_frame) begin
                        done_q <= 1'b1;
                    end else begin
                        frame  <= frame + FW'(1);
                        bitcnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        config_en = '0;
        cfg_ready = 1'b0;
        case (state)
            SHIFT:  cfg_ready = 1'b1;
`ifdef LUT_CFG_PARITY_EN
            PAR:    cfg_ready = 1'b1;
`endif
            COMMIT: config_en[frame] = 1'b1;
            default: ;
        endcase
        cfg_done = done_q;
`ifdef LUT_CFG_PARITY_EN
        cfg_err = err_q;
`else
        cfg_err = 1'b0;
`endif
    end

endmodule
